srg_32bit_div: RTL
==================

SRG_32BIT_DIV -- requirements
Module: srg_32bit_div

Interface
REQ-001 Parameters: none; operand and result width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); captured with start.
REQ-006 dividend  input  32  numerator; captured with start.
REQ-007 divisor  input  32  denominator; captured with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse; results valid in the same cycle.
REQ-010 quotient  output  32  result (LO).
REQ-011 remainder  output  32  result (HI).
REQ-012 div_by_zero  output  1  set with done when captured divisor = 0.

Function
REQ-013 FSM states: IDLE, PREP, ITER, FIX, DONE; encoding is free.
REQ-014 IDLE->PREP on start=1; start while busy is ignored, with no effect on the operation in progress.
REQ-015 PREP: operands converted to magnitudes (signed mode) and stored; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); 5-bit iteration counter cleared; -> ITER.
REQ-016 ITER: radix-2 restoring step per cycle: partial remainder shifted left 1 with next dividend bit; trial subtract of divisor magnitude; quotient bit = NOT borrow; partial remainder replaced only when there is no borrow.
REQ-017 ITER runs exactly 32 cycles (counter 0..31 inclusive); at count 31 -> FIX.
REQ-018 FIX: quotient and remainder negated per the REQ-015 signs (signed mode only); results registered; -> DONE.
REQ-019 DONE: done=1 for exactly one cycle; -> IDLE; start in the DONE cycle is ignored.
REQ-020 Latency (macro undefined): done high exactly 35 cycles after the cycle in which start is sampled high; constant for all operands.
REQ-021 quotient, remainder and div_by_zero hold their values from DONE until the next accepted start completes.
REQ-022 Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (unmodified), div_by_zero = 1; applies to both signed and unsigned modes.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, div_by_zero = 0.
REQ-024 The magnitude of 0x80000000 is treated as unsigned 2^31, with no saturation.

Reset
REQ-025 rst_n=0 at a rising edge: state = IDLE; busy, done, div_by_zero = 0; quotient and remainder = 0; counter cleared.
REQ-026 Reset mid-operation abandons the operation, with no done pulse; the first start after reset release is accepted normally.

Configuration
REQ-027 Macro SRG_DIV_EARLY_OUT_EN, when defined: in PREP, if divisor = 0 or divisor magnitude > dividend magnitude, ITER is skipped (PREP->FIX); done is then high 3 cycles after start is sampled.
REQ-028 In early-out with a nonzero divisor: quotient = 0, remainder = dividend.
REQ-029 With SRG_DIV_EARLY_OUT_EN undefined, all operations use the REQ-020 latency; results are identical in both builds.

Structure
REQ-030 Shared package holds: state enumeration, DIV_W = 32, ITER_CNT = 32, DIV_ZERO_Q = 32'hFFFFFFFF.
REQ-031 The trial subtract is performed by one instance of the team 32-bit CLA adder (srg_32Bit_CLA), with OpB = ~divisor magnitude, cin = 1, and borrow = NOT Cout.
REQ-032 No other sub-modules.

Verification
REQ-033 Unsigned 100 / 7 -> quotient 14, remainder 2, done at cycle 35 (macro undefined).
REQ-034 Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
REQ-036 5 / 0 (both modes) -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1; done at cycle 3 with SRG_DIV_EARLY_OUT_EN defined, cycle 35 without.
REQ-037 A second start pulsed at iteration 10 -> ignored; first result (1000 / 10 -> 100, 0) is unchanged, with a single done pulse.
REQ-038 rst_n low at iteration 10 -> next cycle busy=0, outputs 0, no done; then 9 / 3 -> quotient 3, remainder 0.

Source files
------------

// File: rtl/srg_32bit_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srg_32bit_div_pkg
// Description : Shared types and constants for the 32-bit sequential
//               restoring divider (state enumeration, widths, the
//               divide-by-zero quotient pattern).
// Revision    : 1.0 - initial release
// ============================================================================
package srg_32bit_div_pkg;

    localparam int          DIV_W      = 32;
    localparam int          ITER_CNT   = 32;
    localparam int          CNT_W      = 5;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    // Absolute value of a 32-bit operand when interpreted as signed.
    // 0x80000000 maps to itself, which is read as unsigned 2^31.
    function automatic logic [DIV_W-1:0] mag32(input logic [DIV_W-1:0] x,
                                               input logic             sgn);
        mag32 = (sgn && x[DIV_W-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/srg_32bit_div_cla.sv
`default_nettype none
// ============================================================================
// Module      : srg_32Bit_CLA
// Description : 32-bit carry-lookahead adder built from eight 4-bit
//               lookahead groups; group carries ripple between groups.
// Revision    : 1.0 - initial release
// Ports       : OpA, OpB [31:0] - addends
//               cin             - carry in
//               Sum [31:0]      - OpA + OpB + cin (low 32 bits)
//               Cout            - carry out of bit 31
// ============================================================================
module srg_32Bit_CLA (
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        cin,
    output logic [31:0] Sum,
    output logic        Cout
);

    logic [8:0] w_gc;

    assign w_gc[0] = cin;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [4:0] w_c;

        assign w_g    = OpA[4*gi +: 4] & OpB[4*gi +: 4];
        assign w_p    = OpA[4*gi +: 4] ^ OpB[4*gi +: 4];
        assign w_c[0] = w_gc[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                      | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        assign Sum[4*gi +: 4] = w_p ^ w_c[3:0];
        assign w_gc[gi+1]     = w_c[4];
    end

    assign Cout = w_gc[8];

endmodule
`default_nettype wire

// File: rtl/srg_32bit_div.sv
`default_nettype none
// ============================================================================
// Module      : srg_32bit_div
// Description : 32-bit signed/unsigned sequential divider, one radix-2
//               restoring step per cycle. IDLE -> PREP -> ITER(x32) -> FIX
//               -> DONE; start to done latency is 35 cycles.
// Revision    : 1.0 - initial release
// Macro       : SRG_DIV_EARLY_OUT_EN - when defined, PREP jumps straight to
//               FIX for divisor = 0 or |divisor| > |dividend| (3 cycles).
// Ports       : clk, rst_n (sync, active-low)
//               start, is_signed, dividend[31:0], divisor[31:0] - request
//               busy, done - status; done is a one-cycle pulse
//               quotient[31:0], remainder[31:0], div_by_zero - results,
//               held until the next accepted operation completes
// ============================================================================
module srg_32bit_div
    import srg_32bit_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ITER_CNT - 1);

    div_state_t       r_state;
    div_state_t       w_next;

    logic [DIV_W-1:0] r_dvd_raw;   // dividend exactly as captured
    logic [DIV_W-1:0] r_dsr_raw;   // divisor exactly as captured
    logic             r_signed;
    logic [DIV_W-1:0] r_dvd;       // dividend magnitude; quotient bits shift in at LSB
    logic [DIV_W-1:0] r_dsr;       // divisor magnitude
    logic [DIV_W-1:0] r_rem_p;     // partial remainder
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_early;
    logic [DIV_W-1:0] r_quotient;
    logic [DIV_W-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [DIV_W-1:0] w_dvd_mag;
    logic [DIV_W-1:0] w_dsr_mag;
    logic             w_skip;
    logic [DIV_W-1:0] w_shift;
    logic [DIV_W-1:0] w_sum;
    logic             w_cout;
    logic             w_borrow;

    assign w_dvd_mag = mag32(r_dvd_raw, r_signed);
    assign w_dsr_mag = mag32(r_dsr_raw, r_signed);

`ifdef SRG_DIV_EARLY_OUT_EN
    assign w_skip = (r_dsr_raw == '0) || (w_dsr_mag > w_dvd_mag);
`else
    assign w_skip = 1'b0;
`endif

    // Shifted partial remainder; its true width is 33 bits, the dropped
    // top bit is r_rem_p[31].
    assign w_shift = {r_rem_p[DIV_W-2:0], r_dvd[DIV_W-1]};

    // Trial subtract w_shift - r_dsr as w_shift + ~r_dsr + 1.
    srg_32Bit_CLA u_cla (
        .OpA  (w_shift),
        .OpB  (~r_dsr),
        .cin  (1'b1),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // Borrow is NOT carry-out, except that a set 33rd bit of the shifted
    // remainder guarantees the subtraction fits (divisor < 2^32).
    assign w_borrow = ~w_cout & ~r_rem_p[DIV_W-1];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state / status ----------------
    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE: if (start) w_next = S_PREP;
            S_PREP: w_next = w_skip ? S_FIX : S_ITER;
            S_ITER: if (r_cnt == c_cnt_last) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd_raw     <= '0;
            r_dsr_raw     <= '0;
            r_signed      <= 1'b0;
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_rem_p       <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_early       <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd_raw <= dividend;
                        r_dsr_raw <= divisor;
                        r_signed  <= is_signed;
                    end
                end
                S_PREP: begin
                    r_dvd   <= w_dvd_mag;
                    r_dsr   <= w_dsr_mag;
                    r_rem_p <= '0;
                    r_cnt   <= '0;
                    r_neg_q <= r_signed & (r_dvd_raw[DIV_W-1] ^ r_dsr_raw[DIV_W-1]);
                    r_neg_r <= r_signed & r_dvd_raw[DIV_W-1];
                    r_dz    <= (r_dsr_raw == '0);
                    r_early <= w_skip;
                end
                S_ITER: begin
                    r_rem_p <= w_borrow ? w_shift : w_sum;
                    r_dvd   <= {r_dvd[DIV_W-2:0], ~w_borrow};
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_quotient  <= DIV_ZERO_Q;
                        r_remainder <= r_dvd_raw;
                    end else if (r_early) begin
                        r_quotient  <= '0;
                        r_remainder <= r_dvd_raw;
                    end else begin
                        r_quotient  <= r_neg_q ? (~r_dvd + 32'd1)   : r_dvd;
                        r_remainder <= r_neg_r ? (~r_rem_p + 32'd1) : r_rem_p;
                    end
                    r_div_by_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
